// File: rtl/basic_spi_slave_pkg.sv
// Shared constants for the SPI slave: bus widths and FSM state codes.
// Also holds the helper that MSB-aligns a short tx word in the shifter.
package basic_spi_slave_pkg;

  localparam int DATA_W = 16;
  localparam int LEN_W  = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Move bit len of w up to bit DATA_W-1 so the shifter always
  // sends from its top bit regardless of word length.
  function automatic logic [DATA_W-1:0] msb_align(
    input logic [DATA_W-1:0] w,
    input logic [LEN_W-1:0]  len
  );
    return w << (LEN_W'(DATA_W - 1) - len);
  endfunction

endpackage

// File: rtl/basic_spi_slave_sync_edge.sv
// STAGES-deep synchronizer followed by a registered edge detector.
// Ports: clk, rst, init (reset level), d (async in), q, rise, fall.
module basic_spi_slave_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic init,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{init}};
      prev  <= init;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/basic_spi_slave.sv
// SPI slave: oversampled ss/sck/mosi, MSB-first shift of 1..16 bits.
// Ports: ss/sck/mosi/miso bus, en/oe/we/data CPU side, busy/done/abort.
module basic_spi_slave
  import basic_spi_slave_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ss,
  input  logic        sck,
  input  logic        mosi,
  output logic        miso,
  input  logic        en,
  input  logic        oe,
  input  logic        we,
  input  logic        cpol,
  input  logic        cpha,
  input  logic [3:0]  xfer_len,
  output logic        busy,
  output logic        done,
  output logic        abort,
  inout  wire  [15:0] data
);

  logic [1:0]        state;
  logic              cpol_l;
  logic              cpha_l;
  logic [3:0]        len_l;
  logic [15:0]       tx_packet;
  logic [15:0]       rx_packet;
  logic [15:0]       tx_sh;
  logic [15:0]       rx_sh;
  logic [4:0]        cnt;
  logic              miso_bit;
  logic              armed;
  logic [SYNC_STAGES:0]   flush;
  logic [SYNC_STAGES-1:0] mosi_chain;

  logic ss_s, ss_rise, ss_fall;
  logic sck_s, sck_rise, sck_fall;
  logic mosi_s;
  logic sck_edge, lead, trail;
  logic sample, shift, start;
  logic [4:0] n_bits;

  basic_spi_slave_sync_edge #(.STAGES(SYNC_STAGES)) u_ss (
    .clk  (clk),
    .rst  (rst),
    .init (1'b1),
    .d    (ss),
    .q    (ss_s),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  basic_spi_slave_sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
    .clk  (clk),
    .rst  (rst),
    .init (cpol),
    .d    (sck),
    .q    (sck_s),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  assign mosi_s   = mosi_chain[SYNC_STAGES-1];
  assign sck_edge = sck_rise | sck_fall;
  // Leading edge leaves the idle level, trailing edge returns to it.
  assign lead     = sck_edge & (sck_s != cpol_l);
  assign trail    = sck_edge & (sck_s == cpol_l);
  assign sample   = cpha_l ? trail : lead;
  assign shift    = cpha_l ? lead : trail;
  assign n_bits   = {1'b0, len_l} + 5'd1;
  // armed blocks a start on the fall produced by the synchronizer
  // draining its reset value while the pin is already low.
  assign start    = ss_fall & en & armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cpol_l     <= 1'b0;
      cpha_l     <= 1'b0;
      len_l      <= '0;
      tx_packet  <= '0;
      rx_packet  <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      cnt        <= '0;
      miso_bit   <= 1'b0;
      armed      <= 1'b0;
      flush      <= '0;
      mosi_chain <= '0;
      done       <= 1'b0;
      abort      <= 1'b0;
    end else begin
      done       <= 1'b0;
      abort      <= 1'b0;
      flush      <= {flush[SYNC_STAGES-1:0], 1'b1};
      mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], mosi};
      if (flush[SYNC_STAGES] && ss_s)
        armed <= 1'b1;
      if (we && !oe && state == ST_IDLE && !ss_fall)
        tx_packet <= data;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cpol_l   <= cpol;
            cpha_l   <= cpha;
            len_l    <= xfer_len;
            miso_bit <= tx_packet[xfer_len];
            // cpha=0 already shows the MSB, so skip it in the shifter.
            tx_sh    <= cpha ? msb_align(tx_packet, xfer_len)
                             : msb_align(tx_packet, xfer_len) << 1;
            rx_sh    <= '0;
            cnt      <= '0;
            state    <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (ss_rise) begin
            abort <= 1'b1;
            state <= ST_IDLE;
          end else begin
            if (sample) begin
              rx_sh <= {rx_sh[14:0], mosi_s};
              cnt   <= cnt + 5'd1;
              if (cnt + 5'd1 == n_bits)
                state <= ST_HOLD;
            end
            if (shift) begin
              miso_bit <= tx_sh[15];
              tx_sh    <= tx_sh << 1;
            end
          end
        end
        ST_HOLD: begin
          if (ss_rise) begin
            rx_packet <= rx_sh;
            done      <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign miso = busy ? miso_bit : 1'bz;
  assign data = oe ? rx_packet : 16'bz;

endmodule

// File: tb/tb_basic_spi_slave.sv
// Directed bench for basic_spi_slave acting as the SPI master.
// miso has a pull-up, so an undriven miso reads 1.
module tb_basic_spi_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ss = 1'b1;
  logic        sck = 1'b0;
  logic        mosi = 1'b0;
  logic        en = 1'b1;
  logic        oe = 1'b0;
  logic        we = 1'b0;
  logic        cpol = 1'b0;
  logic        cpha = 1'b0;
  logic [3:0]  xfer_len = 4'd7;
  logic        busy, done, abort;
  logic        tb_en = 1'b0;
  logic [15:0] tb_val = '0;
  wire  [15:0] data;
  wire         miso;

  int n_vec = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  int busy_cyc = 0;
  int bad_done = 0;
  logic busy_q = 1'b0;

  pullup (miso);
  assign data = tb_en ? tb_val : 16'bz;

  always #5 clk = ~clk;

  basic_spi_slave #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .ss       (ss),
    .sck      (sck),
    .mosi     (mosi),
    .miso     (miso),
    .en       (en),
    .oe       (oe),
    .we       (we),
    .cpol     (cpol),
    .cpha     (cpha),
    .xfer_len (xfer_len),
    .busy     (busy),
    .done     (done),
    .abort    (abort),
    .data     (data)
  );

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (abort) abort_cnt <= abort_cnt + 1;
    if (busy) busy_cyc <= busy_cyc + 1;
    if (done && (busy || !busy_q)) bad_done <= bad_done + 1;
    busy_q <= busy;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_tx(input logic [15:0] w);
    tb_val = w;
    tb_en  = 1'b1;
    we     = 1'b1;
    wait_clk(1);
    we     = 1'b0;
    tb_en  = 1'b0;
    wait_clk(1);
  endtask

  task automatic read_rx(output logic [15:0] v);
    oe = 1'b1;
    wait_clk(1);
    v  = data;
    oe = 1'b0;
    wait_clk(1);
  endtask

  task automatic gap(input int i, input int poke_at);
    if (i == poke_at) begin
      tb_val = 16'h00FF;
      tb_en  = 1'b1;
      we     = 1'b1;
      wait_clk(1);
      we     = 1'b0;
      tb_en  = 1'b0;
      wait_clk(7);
    end else begin
      wait_clk(8);
    end
  endtask

  // Master side: nb bits of mo (MSB = bit len), miso captured at
  // each sample edge into mi, right-justified.
  task automatic frame(
    input  logic        pol,
    input  logic        pha,
    input  logic [3:0]  len,
    input  logic [15:0] mo,
    input  int          nb,
    input  bit          raise,
    input  int          poke_at,
    input  int          rst_at,
    output logic [15:0] mi
  );
    logic [15:0] acc;
    int k;
    acc      = '0;
    cpol     = pol;
    cpha     = pha;
    xfer_len = len;
    sck      = pol;
    mosi     = 1'b0;
    wait_clk(8);
    ss = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nb; i++) begin
      k = int'(len) - i;
      if (i == rst_at) begin
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
      end
      if (!pha) begin
        mosi = mo[k];
        gap(i, poke_at);
        acc  = {acc[14:0], miso};
        sck  = ~pol;
        wait_clk(8);
        sck  = pol;
      end else begin
        sck  = ~pol;
        mosi = mo[k];
        gap(i, poke_at);
        acc  = {acc[14:0], miso};
        sck  = pol;
        wait_clk(8);
      end
    end
    wait_clk(8);
    if (raise) begin
      ss = 1'b1;
      wait_clk(10);
    end
    mi = acc;
  endtask

  task automatic test_reset;
    logic [15:0] v;
    rst = 1'b1;
    wait_clk(3);
    if (busy !== 1'b0) begin
      $display("FAIL reset_busy got %b want 0", busy);
      n_bad++;
    end
    n_vec++;
    if (done !== 1'b0) begin
      $display("FAIL reset_done got %b want 0", done);
      n_bad++;
    end
    n_vec++;
    if (abort !== 1'b0) begin
      $display("FAIL reset_abort got %b want 0", abort);
      n_bad++;
    end
    n_vec++;
    if (miso !== 1'b1) begin
      $display("FAIL reset_miso_z got %b want 1(pulled)", miso);
      n_bad++;
    end
    n_vec++;
    rst = 1'b0;
    wait_clk(5);
    read_rx(v);
    if (v !== 16'h0000) begin
      $display("FAIL reset_rx got %h want 0000", v);
      n_bad++;
    end
    n_vec++;
  endtask

  task automatic test_mode0;
    logic [15:0] mi, v;
    int d0, a0;
    write_tx(16'h00A5);
    d0 = done_cnt;
    a0 = abort_cnt;
    frame(0, 0, 4'd7, 16'h003C, 8, 1, -1, -1, mi);
    if (mi !== 16'h00A5) begin
      $display("FAIL m0_miso got %h want 00a5", mi);
      n_bad++;
    end
    n_vec++;
    if (done_cnt - d0 !== 1) begin
      $display("FAIL m0_done got %0d want 1", done_cnt - d0);
      n_bad++;
    end
    n_vec++;
    if (abort_cnt - a0 !== 0) begin
      $display("FAIL m0_abort got %0d want 0", abort_cnt - a0);
      n_bad++;
    end
    n_vec++;
    if (bad_done !== 0) begin
      $display("FAIL m0_busy_done got %0d want 0", bad_done);
      n_bad++;
    end
    n_vec++;
    read_rx(v);
    if (v !== 16'h003C) begin
      $display("FAIL m0_rx got %h want 003c", v);
      n_bad++;
    end
    n_vec++;
  endtask

  task automatic test_mode3;
    logic [15:0] mi, v;
    int d0;
    write_tx(16'hBEEF);
    d0 = done_cnt;
    frame(1, 1, 4'd15, 16'h1234, 16, 1, -1, -1, mi);
    if (mi !== 16'hBEEF) begin
      $display("FAIL m3_miso got %h want beef", mi);
      n_bad++;
    end
    n_vec++;
    if (done_cnt - d0 !== 1) begin
      $display("FAIL m3_done got %0d want 1", done_cnt - d0);
      n_bad++;
    end
    n_vec++;
    read_rx(v);
    if (v !== 16'h1234) begin
      $display("FAIL m3_rx got %h want 1234", v);
      n_bad++;
    end
    n_vec++;
  endtask

  task automatic test_one_bit;
    logic [15:0] mi, v;
    int d0;
    write_tx(16'h0001);
    for (int m = 0; m < 2; m++) begin
      d0 = done_cnt;
      if (m == 0)
        frame(1, 0, 4'd0, 16'h0001, 1, 1, -1, -1, mi);
      else
        frame(0, 1, 4'd0, 16'h0001, 1, 1, -1, -1, mi);
      if (mi !== 16'h0001) begin
        $display("FAIL bit1_miso m%0d got %h want 0001", m, mi);
        n_bad++;
      end
      n_vec++;
      if (done_cnt - d0 !== 1) begin
        $display("FAIL bit1_done m%0d got %0d", m, done_cnt - d0);
        n_bad++;
      end
      n_vec++;
      read_rx(v);
      if (v !== 16'h0001) begin
        $display("FAIL bit1_rx m%0d got %h want 0001", m, v);
        n_bad++;
      end
      n_vec++;
    end
  endtask

  task automatic test_abort;
    logic [15:0] mi, v;
    int d0, a0;
    write_tx(16'h00A5);
    d0 = done_cnt;
    a0 = abort_cnt;
    frame(0, 0, 4'd7, 16'h00FF, 5, 1, -1, -1, mi);
    if (abort_cnt - a0 !== 1) begin
      $display("FAIL ab_abort got %0d want 1", abort_cnt - a0);
      n_bad++;
    end
    n_vec++;
    if (done_cnt - d0 !== 0) begin
      $display("FAIL ab_done got %0d want 0", done_cnt - d0);
      n_bad++;
    end
    n_vec++;
    read_rx(v);
    if (v !== 16'h0001) begin
      $display("FAIL ab_rx_kept got %h want 0001", v);
      n_bad++;
    end
    n_vec++;
    d0 = done_cnt;
    frame(0, 0, 4'd7, 16'h005A, 8, 1, -1, -1, mi);
    if (mi !== 16'h00A5) begin
      $display("FAIL ab_next_miso got %h want 00a5", mi);
      n_bad++;
    end
    n_vec++;
    if (done_cnt - d0 !== 1) begin
      $display("FAIL ab_next_done got %0d want 1", done_cnt - d0);
      n_bad++;
    end
    n_vec++;
    read_rx(v);
    if (v !== 16'h005A) begin
      $display("FAIL ab_next_rx got %h want 005a", v);
      n_bad++;
    end
    n_vec++;
  endtask

  task automatic test_we_busy;
    logic [15:0] mi, v;
    write_tx(16'hC3C3);
    frame(0, 0, 4'd15, 16'h8001, 16, 1, 2, -1, mi);
    if (mi !== 16'hC3C3) begin
      $display("FAIL web_miso got %h want c3c3", mi);
      n_bad++;
    end
    n_vec++;
    frame(0, 1, 4'd15, 16'h7FFE, 16, 1, -1, -1, mi);
    if (mi !== 16'hC3C3) begin
      $display("FAIL web_resend got %h want c3c3", mi);
      n_bad++;
    end
    n_vec++;
    oe = 1'b1;
    we = 1'b1;
    wait_clk(1);
    v  = data;
    oe = 1'b0;
    we = 1'b0;
    wait_clk(1);
    if (v !== 16'h7FFE) begin
      $display("FAIL oewe_data got %h want 7ffe", v);
      n_bad++;
    end
    n_vec++;
    frame(0, 0, 4'd15, 16'h0000, 16, 1, -1, -1, mi);
    if (mi !== 16'hC3C3) begin
      $display("FAIL oewe_nowrite got %h want c3c3", mi);
      n_bad++;
    end
    n_vec++;
  endtask

  task automatic test_rst_mid;
    logic [15:0] mi, v;
    int d0, a0;
    write_tx(16'h00A5);
    d0 = done_cnt;
    a0 = abort_cnt;
    frame(0, 0, 4'd7, 16'h00C3, 8, 0, -1, 3, mi);
    if (busy !== 1'b0) begin
      $display("FAIL rst_busy got %b want 0", busy);
      n_bad++;
    end
    n_vec++;
    if (miso !== 1'b1) begin
      $display("FAIL rst_miso_z got %b want 1(pulled)", miso);
      n_bad++;
    end
    n_vec++;
    ss = 1'b1;
    wait_clk(10);
    if (done_cnt - d0 !== 0) begin
      $display("FAIL rst_done got %0d want 0", done_cnt - d0);
      n_bad++;
    end
    n_vec++;
    if (abort_cnt - a0 !== 0) begin
      $display("FAIL rst_abort got %0d want 0", abort_cnt - a0);
      n_bad++;
    end
    n_vec++;
    write_tx(16'h0096);
    frame(0, 0, 4'd7, 16'h0069, 8, 1, -1, -1, mi);
    if (mi !== 16'h0096) begin
      $display("FAIL rst_next_miso got %h want 0096", mi);
      n_bad++;
    end
    n_vec++;
    read_rx(v);
    if (v !== 16'h0069) begin
      $display("FAIL rst_next_rx got %h want 0069", v);
      n_bad++;
    end
    n_vec++;
  endtask

  task automatic test_en_off;
    logic [15:0] mi;
    int d0, b0;
    en = 1'b0;
    d0 = done_cnt;
    b0 = busy_cyc;
    frame(0, 0, 4'd7, 16'h00AA, 8, 1, -1, -1, mi);
    en = 1'b1;
    if (busy_cyc - b0 !== 0) begin
      $display("FAIL en0_busy got %0d cycles want 0", busy_cyc - b0);
      n_bad++;
    end
    n_vec++;
    if (mi !== 16'h00FF) begin
      $display("FAIL en0_miso_z got %h want 00ff", mi);
      n_bad++;
    end
    n_vec++;
    if (done_cnt - d0 !== 0) begin
      $display("FAIL en0_done got %0d want 0", done_cnt - d0);
      n_bad++;
    end
    n_vec++;
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_one_bit();
    test_abort();
    test_we_busy();
    test_rst_mid();
    test_en_off();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
